// File: rtl/input_event_queue_pkg.sv
// Shared definitions for the spike-event queues (input, aux and out queues).
// Holds the default field widths and the packed event-entry width so that all
// queue flavours agree on the {BT, NID} entry layout.
package input_event_queue_pkg;

  // Biological time: integer part plus DELTAT_WIDTH fractional bits.
  localparam int BT_WIDTH_DEF        = 36;
  localparam int DELTAT_WIDTH_DEF    = 4;
  localparam int NEURON_ID_WIDTH_DEF = 10;
  localparam int DEPTH_DEF           = 16;
  localparam int ADDR_WIDTH_DEF      = 4;

  // Packed entry layout: {BT, NID}, BT in the upper bits.
  localparam int ENTRY_WIDTH_DEF = BT_WIDTH_DEF + NEURON_ID_WIDTH_DEF;

  typedef logic [ENTRY_WIDTH_DEF-1:0] eventWord_t;

endpackage

// File: rtl/input_event_queue_if.sv
// Handshake/bus bundle between SysControl (master) and the input event queue
// (slave).
//   master drives: QueueEnable, Enqueue, Dequeue, BT_In, NID_In
//   slave drives : BT_Head, NID_Head, IsQueueFull, IsQueueEmpty, Count,
//                  Overflow, Underflow, OrderError
interface input_event_queue_if
  import input_event_queue_pkg::*;
#(
  parameter int BT_WIDTH        = BT_WIDTH_DEF,
  parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
);

  logic                       QueueEnable;
  logic                       Enqueue;
  logic                       Dequeue;
  logic [BT_WIDTH-1:0]        BT_In;
  logic [NEURON_ID_WIDTH-1:0] NID_In;

  logic [BT_WIDTH-1:0]        BT_Head;
  logic [NEURON_ID_WIDTH-1:0] NID_Head;
  logic                       IsQueueFull;
  logic                       IsQueueEmpty;
  logic [ADDR_WIDTH:0]        Count;
  logic                       Overflow;
  logic                       Underflow;
  logic                       OrderError;

  modport master (
    output QueueEnable, Enqueue, Dequeue, BT_In, NID_In,
    input  BT_Head, NID_Head, IsQueueFull, IsQueueEmpty, Count,
           Overflow, Underflow, OrderError
  );

  modport slave (
    input  QueueEnable, Enqueue, Dequeue, BT_In, NID_In,
    output BT_Head, NID_Head, IsQueueFull, IsQueueEmpty, Count,
           Overflow, Underflow, OrderError
  );

endinterface

// File: rtl/input_event_queue_mem.sv
// Register-file storage for the event queues: DEPTH entries, one synchronous
// write port and one combinational read port (used for first-word-fall-through
// head visibility). Contents are not reset.
//   Clock  : rising-edge clock
//   wrEn   : write wrData into entry wrAddr at the next edge
//   wrAddr : write pointer
//   wrData : packed {BT, NID} entry
//   rdAddr : read pointer
//   rdData : entry at rdAddr, combinational
module event_queue_mem
  import input_event_queue_pkg::*;
#(
  parameter int WIDTH      = ENTRY_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [WIDTH-1:0]      wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [WIDTH-1:0]      rdData
);

  logic [WIDTH-1:0] memArray [DEPTH];

  always_ff @(posedge Clock) begin
    if (wrEn) begin
      memArray[wrAddr] <= wrData;
    end
  end

  assign rdData = memArray[rdAddr];

endmodule

// File: rtl/input_event_queue.sv
// Time-ordered FIFO of external input spike events, upstream of SysControl and
// the input router. The head entry is always visible so SysControl can compare
// BT_Head against current BT before dequeuing.
//   Clock : rising-edge clock
//   Reset : synchronous, active-low; clears pointers, count, last-BT and flags
//   q     : slave side of input_event_queue_if (push/pop controls, head,
//           full/empty/count and sticky Overflow/Underflow/OrderError)
module input_event_queue
  import input_event_queue_pkg::*;
#(
  parameter int BT_WIDTH        = BT_WIDTH_DEF,
  parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input_event_queue_if.slave q
);

  localparam int ENTRY_WIDTH = BT_WIDTH + NEURON_ID_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]  wrPtr;
  logic [ADDR_WIDTH-1:0]  rdPtr;
  logic [ADDR_WIDTH:0]    count;
  logic [BT_WIDTH-1:0]    lastBt;
  logic                   overflowFlag;
  logic                   underflowFlag;
  logic                   orderErrorFlag;

  logic                   isFull;
  logic                   isEmpty;
  logic                   pushOk;
  logic                   popOk;
  logic [ENTRY_WIDTH-1:0] headWord;

  assign isFull  = (count == FULL_COUNT);
  assign isEmpty = (count == '0);

  // A push into a full queue is allowed when the head leaves in the same
  // cycle; the write lands on the slot being vacated (wrPtr == rdPtr).
  assign pushOk = q.QueueEnable && q.Enqueue && (!isFull || q.Dequeue);
  assign popOk  = q.QueueEnable && q.Dequeue && !isEmpty;

  event_queue_mem #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uMem (
    .Clock  (Clock),
    .wrEn   (pushOk),
    .wrAddr (wrPtr),
    .wrData ({q.BT_In, q.NID_In}),
    .rdAddr (rdPtr),
    .rdData (headWord)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      lastBt         <= '0;
      overflowFlag   <= 1'b0;
      underflowFlag  <= 1'b0;
      orderErrorFlag <= 1'b0;
    end else if (q.QueueEnable) begin
      if (pushOk) begin
        wrPtr  <= wrPtr + 1'b1;
        lastBt <= q.BT_In;
        if (q.BT_In < lastBt) begin
          orderErrorFlag <= 1'b1;
        end
      end
      if (popOk) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= count + {{ADDR_WIDTH{1'b0}}, pushOk} - {{ADDR_WIDTH{1'b0}}, popOk};
      if (q.Enqueue && isFull && !q.Dequeue) begin
        overflowFlag <= 1'b1;
      end
      if (q.Dequeue && isEmpty) begin
        underflowFlag <= 1'b1;
      end
    end
  end

  // Storage is never cleared, so the head is gated to zero when empty.
  assign q.BT_Head      = isEmpty ? '0 : headWord[ENTRY_WIDTH-1:NEURON_ID_WIDTH];
  assign q.NID_Head     = isEmpty ? '0 : headWord[NEURON_ID_WIDTH-1:0];
  assign q.IsQueueFull  = isFull;
  assign q.IsQueueEmpty = isEmpty;
  assign q.Count        = count;
  assign q.Overflow     = overflowFlag;
  assign q.Underflow    = underflowFlag;
  assign q.OrderError   = orderErrorFlag;

endmodule

// File: tb/tb_input_event_queue.sv
// Directed testbench for input_event_queue: reset state, FWFT ordering,
// full/overflow/wrap, underflow, order checking and QueueEnable gating.
module tb_input_event_queue;
  import input_event_queue_pkg::*;

  logic Clock;
  logic Reset;

  int nCompared;
  int nMismatched;

  input_event_queue_if #(
    .BT_WIDTH        (36),
    .NEURON_ID_WIDTH (10),
    .ADDR_WIDTH      (4)
  ) qIf ();

  input_event_queue #(
    .BT_WIDTH        (36),
    .NEURON_ID_WIDTH (10),
    .DEPTH           (16),
    .ADDR_WIDTH      (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .q     (qIf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic enq, input logic deq,
                       input logic [35:0] bt, input logic [9:0] nid);
    qIf.QueueEnable = en;
    qIf.Enqueue     = enq;
    qIf.Dequeue     = deq;
    qIf.BT_In       = bt;
    qIf.NID_In      = nid;
    tick();
    qIf.Enqueue = 1'b0;
    qIf.Dequeue = 1'b0;
  endtask

  task automatic push(input logic [35:0] bt, input logic [9:0] nid);
    drive(1'b1, 1'b1, 1'b0, bt, nid);
  endtask

  task automatic pop();
    drive(1'b1, 1'b0, 1'b1, 36'h0, 10'h0);
  endtask

  task automatic doReset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic checkHead(input string tag, input logic [35:0] bt, input logic [9:0] nid);
    checkVal({tag, ".bt"}, 64'(qIf.BT_Head), 64'(bt));
    checkVal({tag, ".nid"}, 64'(qIf.NID_Head), 64'(nid));
  endtask

  task automatic checkFlags(input string tag, input logic ovf, input logic unf, input logic ord);
    checkVal({tag, ".ovf"}, 64'(qIf.Overflow), 64'(ovf));
    checkVal({tag, ".unf"}, 64'(qIf.Underflow), 64'(unf));
    checkVal({tag, ".ord"}, 64'(qIf.OrderError), 64'(ord));
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    qIf.QueueEnable = 1'b1;
    qIf.Enqueue     = 1'b1;
    qIf.Dequeue     = 1'b0;
    qIf.BT_In       = 36'h55;
    qIf.NID_In      = 10'h3;
    Reset           = 1'b0;

    // Reset held 2 cycles while Enqueue is asserted
    tick();
    tick();
    checkVal("rst.count", 64'(qIf.Count), 64'd0);
    checkVal("rst.empty", 64'(qIf.IsQueueEmpty), 64'd1);
    checkVal("rst.full", 64'(qIf.IsQueueFull), 64'd0);
    checkHead("rst.head", 36'h0, 10'h0);
    checkFlags("rst", 1'b0, 1'b0, 1'b0);
    Reset       = 1'b1;
    qIf.Enqueue = 1'b0;

    push(36'h10, 10'd5);
    checkHead("first", 36'h10, 10'd5);
    checkVal("first.count", 64'(qIf.Count), 64'd1);
    checkVal("first.empty", 64'(qIf.IsQueueEmpty), 64'd0);

    // FWFT ordering with fractional stamps 0.0, 0.5, 1.0
    doReset();
    push(36'h00, 10'd1);
    push(36'h08, 10'd2);
    push(36'h10, 10'd3);
    checkVal("ord3.count", 64'(qIf.Count), 64'd3);
    checkHead("ord3.h0", 36'h00, 10'd1);
    pop();
    checkHead("ord3.h1", 36'h08, 10'd2);
    pop();
    checkHead("ord3.h2", 36'h10, 10'd3);
    pop();
    checkVal("ord3.empty", 64'(qIf.IsQueueEmpty), 64'd1);
    checkHead("ord3.emptyhead", 36'h0, 10'h0);
    checkFlags("ord3", 1'b0, 1'b0, 1'b0);

    // Fill, overflow, push+pop while full, drain with wrap-around
    doReset();
    for (int i = 0; i < 16; i++) begin
      push(36'(2 * i), 10'(100 + i));
    end
    checkVal("full.flag", 64'(qIf.IsQueueFull), 64'd1);
    checkVal("full.count", 64'(qIf.Count), 64'd16);
    push(36'h40, 10'd200);
    checkVal("ovf.count", 64'(qIf.Count), 64'd16);
    checkVal("ovf.flag", 64'(qIf.Overflow), 64'd1);
    checkHead("ovf.head", 36'h0, 10'd100);
    drive(1'b1, 1'b1, 1'b1, 36'h50, 10'd300);
    checkVal("fullpp.count", 64'(qIf.Count), 64'd16);
    checkHead("fullpp.head", 36'h2, 10'd101);
    for (int i = 1; i < 16; i++) begin
      checkHead($sformatf("drain%0d", i), 36'(2 * i), 10'(100 + i));
      pop();
    end
    checkHead("drain.tail", 36'h50, 10'd300);
    pop();
    checkVal("drain.empty", 64'(qIf.IsQueueEmpty), 64'd1);
    checkFlags("drain", 1'b1, 1'b0, 1'b0);

    // Underflow, and push+pop while empty / at count 1
    doReset();
    pop();
    checkVal("unf.flag", 64'(qIf.Underflow), 64'd1);
    checkVal("unf.count", 64'(qIf.Count), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 36'h30, 10'd7);
    checkVal("emptypp.count", 64'(qIf.Count), 64'd1);
    checkHead("emptypp.head", 36'h30, 10'd7);
    drive(1'b1, 1'b1, 1'b1, 36'h31, 10'd8);
    checkVal("onepp.count", 64'(qIf.Count), 64'd1);
    checkHead("onepp.head", 36'h31, 10'd8);

    // Order error, entry still stored; equal stamps are legal
    doReset();
    push(36'h20, 10'd1);
    push(36'h18, 10'd2);
    checkVal("oerr.flag", 64'(qIf.OrderError), 64'd1);
    checkVal("oerr.count", 64'(qIf.Count), 64'd2);
    checkHead("oerr.h0", 36'h20, 10'd1);
    pop();
    checkHead("oerr.h1", 36'h18, 10'd2);
    doReset();
    checkVal("oerr.rst", 64'(qIf.OrderError), 64'd0);
    push(36'h18, 10'd4);
    push(36'h18, 10'd5);
    checkVal("oeq.flag", 64'(qIf.OrderError), 64'd0);

    // QueueEnable=0 freezes everything
    doReset();
    push(36'h40, 10'd9);
    push(36'h41, 10'd10);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 36'h7, 10'd11);
    end
    checkVal("dis.count", 64'(qIf.Count), 64'd2);
    checkHead("dis.head", 36'h40, 10'd9);
    checkFlags("dis", 1'b0, 1'b0, 1'b0);
    doReset();
    drive(1'b0, 1'b1, 1'b1, 36'h1, 10'd1);
    drive(1'b0, 1'b0, 1'b1, 36'h0, 10'd0);
    checkVal("disempty.count", 64'(qIf.Count), 64'd0);
    checkVal("disempty.unf", 64'(qIf.Underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
